// File: rtl/dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// dcache_mem_responder: in-order fill/store queues with fixed memory latency
// Revision: 1.0
// ============================================================================
`ifndef DCACHE_BLOCK_ADDR_BITS
`define DCACHE_BLOCK_ADDR_BITS 12
`endif
`ifndef DCACHE_TAG_BITS
`define DCACHE_TAG_BITS 6
`endif
`ifndef DCACHE_INDEX_BITS
`define DCACHE_INDEX_BITS 6
`endif
`ifndef DCACHE_BITS_IN_LINE
`define DCACHE_BITS_IN_LINE 128
`endif
`ifndef DCACHE_ST_ADDR_BITS
`define DCACHE_ST_ADDR_BITS 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module dcache_mem_responder #(
  parameter int LD_LATENCY = 8,
  parameter int LDQ_DEPTH  = 4,
  parameter int ST_LATENCY = 4,
  parameter int STQ_DEPTH  = 4
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [`DCACHE_BLOCK_ADDR_BITS-1:0]  dc2memLdAddr_i,
  input  logic                                dc2memLdValid_i,
  input  logic [1:0]                          dc2memReqWay_i,
  output logic [`DCACHE_TAG_BITS-1:0]         mem2dcLdTag_o,
  output logic [`DCACHE_INDEX_BITS-1:0]       mem2dcLdIndex_o,
  output logic [`DCACHE_BITS_IN_LINE-1:0]     mem2dcLdData_o,
  output logic                                mem2dcLdValid_o,
  input  logic [`DCACHE_ST_ADDR_BITS-1:0]     dc2memStAddr_i,
  input  logic [`SIZE_DATA-1:0]               dc2memStData_i,
  input  logic [2:0]                          dc2memStSize_i,
  input  logic                                dc2memStValid_i,
  output logic                                mem2dcStComplete_o,
  output logic                                mem2dcStStall_o,
  output logic [`DCACHE_BLOCK_ADDR_BITS-1:0]  bsRdAddr_o,
  output logic                                bsRdEn_o,
  input  logic [`DCACHE_BITS_IN_LINE-1:0]     bsRdData_i,
  output logic [`DCACHE_ST_ADDR_BITS-1:0]     bsWrAddr_o,
  output logic [`SIZE_DATA-1:0]               bsWrData_o,
  output logic [2:0]                          bsWrSize_o,
  output logic                                bsWrEn_o,
  output logic                                ldOverflow_o,
  output logic                                stOverflow_o
);

  localparam int c_BA_W    = `DCACHE_BLOCK_ADDR_BITS;
  localparam int c_TAG_W   = `DCACHE_TAG_BITS;
  localparam int c_IDX_W   = `DCACHE_INDEX_BITS;
  localparam int c_SA_W    = `DCACHE_ST_ADDR_BITS;
  localparam int c_SD_W    = `SIZE_DATA;
  localparam int c_LDQ_AW  = (LDQ_DEPTH > 1) ? $clog2(LDQ_DEPTH) : 1;
  localparam int c_LDQ_CW  = $clog2(LDQ_DEPTH + 1);
  localparam int c_STQ_AW  = (STQ_DEPTH > 1) ? $clog2(STQ_DEPTH) : 1;
  localparam int c_STQ_CW  = $clog2(STQ_DEPTH + 1);
  localparam int c_AGE_W   = $clog2(LD_LATENCY);
  localparam int c_STC_W   = (ST_LATENCY > 1) ? $clog2(ST_LATENCY) : 1;
  localparam logic [c_AGE_W-1:0] c_AGE_MAX   = c_AGE_W'(LD_LATENCY - 1);
  localparam logic [c_AGE_W-1:0] c_AGE_ISSUE = c_AGE_W'(LD_LATENCY - 2);
  localparam logic [c_STC_W-1:0] c_ST_FIRE   = c_STC_W'(ST_LATENCY - 1);

  // ---------------- load queue ----------------
  logic [c_BA_W-1:0]    r_ldq_addr [LDQ_DEPTH];
  logic [1:0]           r_ldq_way  [LDQ_DEPTH];
  logic [c_AGE_W-1:0]   r_ldq_age  [LDQ_DEPTH];
  logic [LDQ_DEPTH-1:0] r_ldq_vld;
  logic [c_LDQ_AW-1:0]  r_ld_wptr, r_ld_rptr;
  logic [c_LDQ_CW-1:0]  r_ld_count;
  logic                 r_ld_ovf;
  logic                 r_ret_vld;
  logic [c_BA_W-1:0]    r_ret_addr;

  logic w_ld_full, w_ld_push, w_ld_issue, w_unused_way;

  assign w_ld_full    = (r_ld_count == c_LDQ_CW'(LDQ_DEPTH));
  assign w_ld_push    = dc2memLdValid_i && !w_ld_full;
  assign w_ld_issue   = r_ldq_vld[r_ld_rptr] && (r_ldq_age[r_ld_rptr] >= c_AGE_ISSUE);
  assign w_unused_way = ^r_ldq_way[r_ld_rptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      r_ld_wptr  <= '0;
      r_ld_rptr  <= '0;
      r_ld_count <= '0;
      r_ldq_vld  <= '0;
      r_ld_ovf   <= 1'b0;
      r_ret_vld  <= 1'b0;
      r_ret_addr <= '0;
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        r_ldq_addr[i] <= '0;
        r_ldq_way[i]  <= '0;
        r_ldq_age[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < LDQ_DEPTH; i++) begin
        if (r_ldq_vld[i] && (r_ldq_age[i] != c_AGE_MAX))
          r_ldq_age[i] <= r_ldq_age[i] + 1'b1;
      end
      if (w_ld_issue) begin
        r_ldq_vld[r_ld_rptr] <= 1'b0;
        r_ld_rptr <= (r_ld_rptr == c_LDQ_AW'(LDQ_DEPTH - 1)) ? '0 : r_ld_rptr + 1'b1;
      end
      // Push slot never equals the issuing slot: full blocks push, empty blocks issue.
      if (w_ld_push) begin
        r_ldq_addr[r_ld_wptr] <= dc2memLdAddr_i;
        r_ldq_way[r_ld_wptr]  <= dc2memReqWay_i;
        r_ldq_age[r_ld_wptr]  <= '0;
        r_ldq_vld[r_ld_wptr]  <= 1'b1;
        r_ld_wptr <= (r_ld_wptr == c_LDQ_AW'(LDQ_DEPTH - 1)) ? '0 : r_ld_wptr + 1'b1;
      end
      r_ld_count <= r_ld_count + c_LDQ_CW'(w_ld_push) - c_LDQ_CW'(w_ld_issue);
      if (dc2memLdValid_i && w_ld_full)
        r_ld_ovf <= 1'b1;
      r_ret_vld <= w_ld_issue;
      if (w_ld_issue)
        r_ret_addr <= r_ldq_addr[r_ld_rptr];
    end
  end

  assign bsRdEn_o        = w_ld_issue;
  assign bsRdAddr_o      = w_ld_issue ? r_ldq_addr[r_ld_rptr] : '0;
  assign mem2dcLdValid_o = r_ret_vld;
  assign mem2dcLdTag_o   = r_ret_addr[c_BA_W-1 -: c_TAG_W];
  assign mem2dcLdIndex_o = r_ret_addr[c_IDX_W-1:0];
  assign mem2dcLdData_o  = r_ret_vld ? bsRdData_i : '0;
  assign ldOverflow_o    = r_ld_ovf;

  // ---------------- store queue ----------------
  logic [c_SA_W-1:0]   r_stq_addr [STQ_DEPTH];
  logic [c_SD_W-1:0]   r_stq_data [STQ_DEPTH];
  logic [2:0]          r_stq_size [STQ_DEPTH];
  logic [c_STQ_AW-1:0] r_st_wptr, r_st_rptr;
  logic [c_STQ_CW-1:0] r_st_count;
  logic [c_STC_W-1:0]  r_st_cnt;
  logic                r_st_ovf;

  logic w_st_stall, w_st_push, w_st_head_vld, w_st_fire;

  assign w_st_stall    = (r_st_count == c_STQ_CW'(STQ_DEPTH));
  assign w_st_push     = dc2memStValid_i && !w_st_stall;
  assign w_st_head_vld = (r_st_count != '0);
  assign w_st_fire     = w_st_head_vld && (r_st_cnt == c_ST_FIRE);

  always_ff @(posedge clk) begin
    if (reset) begin
      r_st_wptr  <= '0;
      r_st_rptr  <= '0;
      r_st_count <= '0;
      r_st_cnt   <= '0;
      r_st_ovf   <= 1'b0;
      for (int i = 0; i < STQ_DEPTH; i++) begin
        r_stq_addr[i] <= '0;
        r_stq_data[i] <= '0;
        r_stq_size[i] <= '0;
      end
    end else begin
      if (w_st_fire) begin
        r_st_cnt  <= '0;
        r_st_rptr <= (r_st_rptr == c_STQ_AW'(STQ_DEPTH - 1)) ? '0 : r_st_rptr + 1'b1;
      end else if (w_st_head_vld) begin
        r_st_cnt <= r_st_cnt + 1'b1;
      end
      if (w_st_push) begin
        r_stq_addr[r_st_wptr] <= dc2memStAddr_i;
        r_stq_data[r_st_wptr] <= dc2memStData_i;
        r_stq_size[r_st_wptr] <= dc2memStSize_i;
        r_st_wptr <= (r_st_wptr == c_STQ_AW'(STQ_DEPTH - 1)) ? '0 : r_st_wptr + 1'b1;
      end
      r_st_count <= r_st_count + c_STQ_CW'(w_st_push) - c_STQ_CW'(w_st_fire);
      if (dc2memStValid_i && w_st_stall)
        r_st_ovf <= 1'b1;
    end
  end

  assign bsWrEn_o           = w_st_fire;
  assign bsWrAddr_o         = w_st_fire ? r_stq_addr[r_st_rptr] : '0;
  assign bsWrData_o         = w_st_fire ? r_stq_data[r_st_rptr] : '0;
  assign bsWrSize_o         = w_st_fire ? r_stq_size[r_st_rptr] : '0;
  assign mem2dcStComplete_o = w_st_fire;
  assign mem2dcStStall_o    = w_st_stall;
  assign stOverflow_o       = r_st_ovf;

endmodule
`default_nettype wire

// File: tb/tb_dcache_mem_responder.sv
`default_nettype none
// ============================================================================
// tb_dcache_mem_responder: directed self-checking bench with backing-store model
// Revision: 1.0
// ============================================================================
`ifndef DCACHE_BLOCK_ADDR_BITS
`define DCACHE_BLOCK_ADDR_BITS 12
`endif
`ifndef DCACHE_TAG_BITS
`define DCACHE_TAG_BITS 6
`endif
`ifndef DCACHE_INDEX_BITS
`define DCACHE_INDEX_BITS 6
`endif
`ifndef DCACHE_BITS_IN_LINE
`define DCACHE_BITS_IN_LINE 128
`endif
`ifndef DCACHE_ST_ADDR_BITS
`define DCACHE_ST_ADDR_BITS 16
`endif
`ifndef SIZE_DATA
`define SIZE_DATA 32
`endif

module tb_dcache_mem_responder;

  logic         clk;
  logic         reset;
  logic [11:0]  dc2memLdAddr_i;
  logic         dc2memLdValid_i;
  logic [1:0]   dc2memReqWay_i;
  logic [5:0]   mem2dcLdTag_o;
  logic [5:0]   mem2dcLdIndex_o;
  logic [127:0] mem2dcLdData_o;
  logic         mem2dcLdValid_o;
  logic [15:0]  dc2memStAddr_i;
  logic [31:0]  dc2memStData_i;
  logic [2:0]   dc2memStSize_i;
  logic         dc2memStValid_i;
  logic         mem2dcStComplete_o;
  logic         mem2dcStStall_o;
  logic [11:0]  bsRdAddr_o;
  logic         bsRdEn_o;
  logic [127:0] bsRdData_i;
  logic [15:0]  bsWrAddr_o;
  logic [31:0]  bsWrData_o;
  logic [2:0]   bsWrSize_o;
  logic         bsWrEn_o;
  logic         ldOverflow_o;
  logic         stOverflow_o;

  dcache_mem_responder #(
    .LD_LATENCY(8), .LDQ_DEPTH(4), .ST_LATENCY(4), .STQ_DEPTH(4)
  ) dut (
    .clk(clk), .reset(reset),
    .dc2memLdAddr_i(dc2memLdAddr_i), .dc2memLdValid_i(dc2memLdValid_i),
    .dc2memReqWay_i(dc2memReqWay_i),
    .mem2dcLdTag_o(mem2dcLdTag_o), .mem2dcLdIndex_o(mem2dcLdIndex_o),
    .mem2dcLdData_o(mem2dcLdData_o), .mem2dcLdValid_o(mem2dcLdValid_o),
    .dc2memStAddr_i(dc2memStAddr_i), .dc2memStData_i(dc2memStData_i),
    .dc2memStSize_i(dc2memStSize_i), .dc2memStValid_i(dc2memStValid_i),
    .mem2dcStComplete_o(mem2dcStComplete_o), .mem2dcStStall_o(mem2dcStStall_o),
    .bsRdAddr_o(bsRdAddr_o), .bsRdEn_o(bsRdEn_o), .bsRdData_i(bsRdData_i),
    .bsWrAddr_o(bsWrAddr_o), .bsWrData_o(bsWrData_o), .bsWrSize_o(bsWrSize_o),
    .bsWrEn_o(bsWrEn_o), .ldOverflow_o(ldOverflow_o), .stOverflow_o(stOverflow_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int edge_n = 0;
  always @(posedge clk) edge_n <= edge_n + 1;

  logic [209:0] outs;
  assign outs = {mem2dcLdTag_o, mem2dcLdIndex_o, mem2dcLdData_o, mem2dcLdValid_o,
                 mem2dcStComplete_o, mem2dcStStall_o, bsRdAddr_o, bsRdEn_o,
                 bsWrAddr_o, bsWrData_o, bsWrSize_o, bsWrEn_o, ldOverflow_o, stOverflow_o};

  // Unwritten lines read back a per-address pattern; 0x123 holds 0xA5 bytes.
  function automatic logic [127:0] line_pat(input logic [11:0] a);
    if (a == 12'h123) return {16{8'hA5}};
    return {4{4'hD, 4'h0, a, a}};
  endfunction

  // Write-first backing store with one-cycle read latency.
  logic [127:0] mem    [4096];
  logic         wr_vld [4096];
  always @(posedge clk) begin : b_mem
    logic [127:0] line;
    if (bsWrEn_o) begin
      line = (wr_vld[bsWrAddr_o[15:4]] === 1'b1) ? mem[bsWrAddr_o[15:4]] : line_pat(bsWrAddr_o[15:4]);
      line[bsWrAddr_o[3:2]*32 +: 32] = bsWrData_o;
      mem[bsWrAddr_o[15:4]]    <= line;
      wr_vld[bsWrAddr_o[15:4]] <= 1'b1;
    end
    if (bsRdEn_o) begin
      line = (wr_vld[bsRdAddr_o] === 1'b1) ? mem[bsRdAddr_o] : line_pat(bsRdAddr_o);
      if (bsWrEn_o && (bsWrAddr_o[15:4] == bsRdAddr_o))
        line[bsWrAddr_o[3:2]*32 +: 32] = bsWrData_o;
      bsRdData_i <= line;
    end
  end

  typedef struct packed {
    int           e;
    logic [5:0]   tag;
    logic [5:0]   idx;
    logic [127:0] data;
  } fill_t;

  fill_t       fills[$];
  int          comps[$];
  logic [15:0] comp_addr[$];
  logic [31:0] comp_data[$];
  int          issues[$];

  always @(negedge clk) begin : b_mon
    fill_t f;
    if (mem2dcLdValid_o === 1'b1) begin
      f.e = edge_n; f.tag = mem2dcLdTag_o; f.idx = mem2dcLdIndex_o; f.data = mem2dcLdData_o;
      fills.push_back(f);
    end
    if (mem2dcStComplete_o === 1'b1) begin
      comps.push_back(edge_n);
      comp_addr.push_back(bsWrAddr_o);
      comp_data.push_back(bsWrData_o);
    end
    if (bsRdEn_o === 1'b1) issues.push_back(edge_n);
  end

  task automatic clear_logs();
    fills.delete(); comps.delete(); comp_addr.delete(); comp_data.delete(); issues.delete();
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    repeat (3) @(negedge clk);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL reset_outputs: got %h want 0", outs); end
    reset = 1'b0;
    @(negedge clk);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL idle_outputs: got %h want 0", outs); end
  endtask

  task automatic test_single_load();
    int req_e;
    clear_logs();
    dc2memLdAddr_i = 12'h123; dc2memLdValid_i = 1'b1; dc2memReqWay_i = 2'd3;
    req_e = edge_n + 1;
    @(negedge clk);
    dc2memLdValid_i = 1'b0;
    repeat (12) @(negedge clk);
    total++;
    if (fills.size() != 1) begin bad++; $display("FAIL single_fill_count: got %0d want 1", fills.size()); end
    if (fills.size() > 0) begin
      total++;
      if (fills[0].e != req_e + 7) begin bad++; $display("FAIL single_latency: got edge %0d want %0d", fills[0].e, req_e + 7); end
      total++;
      if (fills[0].tag !== 6'h04 || fills[0].idx !== 6'h23) begin
        bad++; $display("FAIL single_tag_idx: got %h/%h want 04/23", fills[0].tag, fills[0].idx);
      end
      total++;
      if (fills[0].data !== {16{8'hA5}}) begin bad++; $display("FAIL single_data: got %h want a5..a5", fills[0].data); end
    end
    total++;
    if (issues.size() != 1 || (issues.size() > 0 && issues[0] != req_e + 6)) begin
      bad++; $display("FAIL single_issue: got %0d issues want 1 at edge %0d", issues.size(), req_e + 6);
    end
  endtask

  task automatic test_back_to_back();
    int req_e;
    clear_logs();
    req_e = edge_n + 1;
    for (int i = 0; i < 4; i++) begin
      dc2memLdAddr_i = 12'h010 + 12'(i); dc2memLdValid_i = 1'b1;
      @(negedge clk);
    end
    dc2memLdValid_i = 1'b0;
    repeat (14) @(negedge clk);
    total++;
    if (fills.size() != 4) begin bad++; $display("FAIL b2b_count: got %0d want 4", fills.size()); end
    for (int i = 0; i < 4 && i < fills.size(); i++) begin
      total++;
      if (fills[i].e != req_e + 7 + i || fills[i].idx !== 6'h10 + 6'(i) || fills[i].tag !== 6'h00 ||
          fills[i].data !== line_pat(12'h010 + 12'(i))) begin
        bad++; $display("FAIL b2b_fill%0d: got edge %0d idx %h want edge %0d idx %h", i,
                        fills[i].e, fills[i].idx, req_e + 7 + i, 6'h10 + 6'(i));
      end
    end
  endtask

  task automatic test_ld_overflow();
    pulse_reset();
    clear_logs();
    total++;
    if (ldOverflow_o !== 1'b0) begin bad++; $display("FAIL ldovf_clear: got %b want 0", ldOverflow_o); end
    for (int i = 0; i < 5; i++) begin
      dc2memLdAddr_i = 12'h020 + 12'(i); dc2memLdValid_i = 1'b1;
      @(negedge clk);
    end
    dc2memLdValid_i = 1'b0;
    total++;
    if (ldOverflow_o !== 1'b1) begin bad++; $display("FAIL ldovf_set: got %b want 1", ldOverflow_o); end
    repeat (14) @(negedge clk);
    total++;
    if (fills.size() != 4) begin bad++; $display("FAIL ldovf_fills: got %0d want 4", fills.size()); end
    if (fills.size() == 4) begin
      total++;
      if (fills[3].idx !== 6'h23) begin bad++; $display("FAIL ldovf_last: got idx %h want 23", fills[3].idx); end
    end
    total++;
    if (ldOverflow_o !== 1'b1) begin bad++; $display("FAIL ldovf_sticky: got %b want 1", ldOverflow_o); end
  endtask

  task automatic test_stores();
    int s_e;
    pulse_reset();
    clear_logs();
    s_e = edge_n + 1;
    for (int i = 0; i < 5; i++) begin
      dc2memStAddr_i = 16'h0100 + 16'(4 * i); dc2memStData_i = 32'h1111_0000 + 32'(i);
      dc2memStSize_i = 3'b010; dc2memStValid_i = 1'b1;
      @(negedge clk);
      if (i == 2) begin
        total++;
        if (mem2dcStStall_o !== 1'b0) begin bad++; $display("FAIL st_stall_early: got %b want 0", mem2dcStStall_o); end
      end
      if (i == 3) begin
        total++;
        if (mem2dcStStall_o !== 1'b1) begin bad++; $display("FAIL st_stall_full: got %b want 1", mem2dcStStall_o); end
      end
      if (i == 4) begin
        total++;
        if (mem2dcStStall_o !== 1'b0 || stOverflow_o !== 1'b1) begin
          bad++; $display("FAIL st_after_pop: got stall %b ovf %b want 0 1", mem2dcStStall_o, stOverflow_o);
        end
      end
    end
    dc2memStValid_i = 1'b0;
    repeat (16) @(negedge clk);
    total++;
    if (comps.size() != 4) begin bad++; $display("FAIL st_count: got %0d want 4", comps.size()); end
    for (int i = 0; i < 4 && i < comps.size(); i++) begin
      total++;
      if (comps[i] != s_e + 3 + 4 * i || comp_addr[i] !== 16'h0100 + 16'(4 * i) ||
          comp_data[i] !== 32'h1111_0000 + 32'(i)) begin
        bad++; $display("FAIL st_complete%0d: got edge %0d addr %h data %h want edge %0d addr %h data %h", i,
                        comps[i], comp_addr[i], comp_data[i], s_e + 3 + 4 * i,
                        16'h0100 + 16'(4 * i), 32'h1111_0000 + 32'(i));
      end
    end
  endtask

  task automatic test_write_first();
    int l_e;
    logic [127:0] exp_line;
    pulse_reset();
    clear_logs();
    exp_line = line_pat(12'h040);
    exp_line[95:64] = 32'hDEAD_BEEF;
    l_e = edge_n + 1;
    dc2memLdAddr_i = 12'h040; dc2memLdValid_i = 1'b1;
    @(negedge clk);
    dc2memLdValid_i = 1'b0;
    repeat (2) @(negedge clk);
    dc2memStAddr_i = 16'h0408; dc2memStData_i = 32'hDEAD_BEEF; dc2memStSize_i = 3'b010;
    dc2memStValid_i = 1'b1;
    @(negedge clk);
    dc2memStValid_i = 1'b0;
    repeat (10) @(negedge clk);
    total++;
    if (issues.size() != 1 || comps.size() != 1 ||
        (issues.size() > 0 && issues[0] != l_e + 6) || (comps.size() > 0 && comps[0] != l_e + 6)) begin
      bad++; $display("FAIL wf_same_cycle: got %0d issues %0d completes want both at edge %0d",
                      issues.size(), comps.size(), l_e + 6);
    end
    total++;
    if (fills.size() != 1 || (fills.size() > 0 && fills[0].data !== exp_line)) begin
      bad++; $display("FAIL wf_data: got %0d fills data %h want %h", fills.size(),
                      (fills.size() > 0) ? fills[0].data : 128'h0, exp_line);
    end
  endtask

  task automatic test_reset_mid();
    pulse_reset();
    clear_logs();
    for (int i = 0; i < 3; i++) begin
      dc2memLdAddr_i = 12'h030 + 12'(i); dc2memLdValid_i = 1'b1;
      dc2memStAddr_i = 16'h0200 + 16'(4 * i); dc2memStData_i = 32'h5555_0000 + 32'(i);
      dc2memStValid_i = (i < 2);
      @(negedge clk);
    end
    dc2memLdValid_i = 1'b0; dc2memStValid_i = 1'b0;
    reset = 1'b1;
    @(negedge clk);
    total++;
    if (outs !== '0) begin bad++; $display("FAIL midreset_outputs: got %h want 0", outs); end
    reset = 1'b0;
    repeat (20) @(negedge clk);
    total++;
    if (fills.size() != 0 || comps.size() != 0) begin
      bad++; $display("FAIL midreset_quiet: got %0d fills %0d completes want 0 0", fills.size(), comps.size());
    end
  endtask

  initial begin
    reset = 1'b1;
    dc2memLdAddr_i = '0; dc2memLdValid_i = 1'b0; dc2memReqWay_i = '0;
    dc2memStAddr_i = '0; dc2memStData_i = '0; dc2memStSize_i = '0; dc2memStValid_i = 1'b0;
    test_reset();
    test_single_load();
    test_back_to_back();
    test_ld_overflow();
    test_stores();
    test_write_first();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/dcache_mem_responder.md
# dcache_mem_responder

Memory-side responder for the data cache's miss and store-through interface. It accepts block-fill requests and store writes from the LSU data cache, holds them in small in-order queues, and models a fixed memory latency. It then returns fills (tag, index, line data) and store completions with back-pressure. It sits between the LSU and the backing data memory: in simulation it fronts the data RAM model, and in FPGA builds it fronts the memory controller.

## Interface
Parameters:
- LD_LATENCY, 8: cycles from load-request sample to fill valid; minimum 2.
- LDQ_DEPTH, 4: outstanding fill requests; power of 2.
- ST_LATENCY, 4: cycles a store occupies the queue head before it is written; minimum 1.
- STQ_DEPTH, 4: buffered stores; power of 2.

Ports:
- clk, in, 1: clock; all logic on posedge.
- reset, in, 1: synchronous, active-high.
- dc2memLdAddr_i, in, `DCACHE_BLOCK_ADDR_BITS: block address, {tag, index}.
- dc2memLdValid_i, in, 1: fill request, one request per cycle high.
- dc2memReqWay_i, in, 2: victim way; queued with the request, unused otherwise.
- mem2dcLdTag_o, out, `DCACHE_TAG_BITS: tag of the returned line.
- mem2dcLdIndex_o, out, `DCACHE_INDEX_BITS: index of the returned line.
- mem2dcLdData_o, out, `DCACHE_BITS_IN_LINE: line data.
- mem2dcLdValid_o, out, 1: fill valid, single-cycle pulse per fill.
- dc2memStAddr_i, in, `DCACHE_ST_ADDR_BITS: store address.
- dc2memStData_i, in, `SIZE_DATA: store data.
- dc2memStSize_i, in, 3: store size code.
- dc2memStValid_i, in, 1: store request.
- mem2dcStComplete_o, out, 1: one-cycle pulse when a store is written to memory.
- mem2dcStStall_o, out, 1: store queue full.
- bsRdAddr_o, out, `DCACHE_BLOCK_ADDR_BITS: backing-store line read address.
- bsRdEn_o, out, 1: backing-store read enable.
- bsRdData_i, in, `DCACHE_BITS_IN_LINE: read data, valid the cycle after bsRdEn_o.
- bsWrAddr_o, out, `DCACHE_ST_ADDR_BITS: backing-store write address.
- bsWrData_o, out, `SIZE_DATA: backing-store write data.
- bsWrSize_o, out, 3: backing-store write size code.
- bsWrEn_o, out, 1: backing-store write enable.
- ldOverflow_o, out, 1: sticky error; a request arrived while the load queue was full.
- stOverflow_o, out, 1: sticky error; a store arrived while mem2dcStStall_o was high.

## Operation
- Load queue: circular FIFO with entries {addr, way, age}.
  - A request is pushed on a posedge where dc2memLdValid_i=1 and the queue is not full.
  - If the queue is full, the request is dropped and ldOverflow_o is set.
  - Each valid entry's age increments every cycle and saturates at LD_LATENCY-1; a newly pushed entry starts at age 0.
- Issue: when the head is valid and its age is LD_LATENCY-2 or more, drive bsRdEn_o=1 with bsRdAddr_o=head.addr and pop the head. At most one issue per cycle.
- Return: on the cycle after an issue, mem2dcLdValid_o=1 with data=bsRdData_i, tag=addr[MSB -: `DCACHE_TAG_BITS] and index=addr[`DCACHE_INDEX_BITS-1:0]. The issued address is held in a one-stage return register.
- Fills return strictly in request order. Duplicate requests for the same block are serviced independently, so the cache sees two fills.
- Store queue: FIFO with entries {addr, data, size}.
  - A store is pushed when dc2memStValid_i=1 and mem2dcStStall_o=0.
  - If mem2dcStStall_o=1, the store is dropped and stOverflow_o is set.
  - mem2dcStStall_o = (stCount == STQ_DEPTH), decoded from the registered count.
- Drain: a head counter counts cycles while the head is valid. When the count reaches ST_LATENCY-1:
  - drive bsWrEn_o=1 with the head fields, and pulse mem2dcStComplete_o in the same cycle;
  - pop the head and clear the counter.
  - The next head begins counting the following cycle.
- Push and pop on the same edge of either queue are both honoured and leave the count unchanged. A push while full is dropped even if a pop occurs on that edge.
- Ordering between paths: the backing store is write-first. A line read issued in the same cycle as a write to an address inside that line returns the new data. There is no other ordering between loads and stores.

## Timing
- Reset values:
  - all outputs are 0 (this includes bs* enables, mem2dcLdValid_o, mem2dcStComplete_o, mem2dcStStall_o and both overflow flags);
  - queues are empty and all counters are 0.
- Reset mid-operation discards all queued and in-flight requests; no fill or complete is emitted after reset.
- Load latency: a request sampled at edge T gives mem2dcLdValid_o high during cycle T+LD_LATENCY. The bsRdEn_o issue occurs in cycle T+LD_LATENCY-1.
- Load throughput is 1 fill/cycle; back-to-back requests produce back-to-back fills.
- Store latency: a store sampled at edge T into an empty queue completes in cycle T+ST_LATENCY.
- Store throughput is 1 store per ST_LATENCY cycles.
- mem2dcStStall_o rises the cycle after the push that fills the queue. It falls the cycle after the first pop.

## Test plan
- LD_LATENCY=8, with line data 0xA5…A5 at addr 0x123: single request at edge 10 -> mem2dcLdValid_o high only in cycle 18, tag/index equal to the split of 0x123, data 0xA5…A5.
- Requests to 0x10, 0x11, 0x12, 0x13 on consecutive edges 0–3 -> fills in cycles 8, 9, 10, 11, in that order.
- Fifth request with LDQ_DEPTH=4 and the queue full -> ldOverflow_o=1, and exactly 4 fills are returned.
- STQ_DEPTH=4, ST_LATENCY=4: 5 stores on consecutive edges -> stall high after the 4th store, 5th store dropped, stOverflow_o=1, completes at cycles 4, 8, 12, 16, and stall low again after the first complete.
- Store to a word in line 0x40 completes in the same cycle a read of 0x40 issues -> the fill carries the new word.
- Assert reset with 3 loads and 2 stores pending -> all outputs 0 next cycle, and no fill or complete is emitted for 20 cycles afterwards.
